// File: rtl/alu_result_collector.sv
// alu_result_collector: tracks each op issued to the ALU, picks the active
// unit's registered result one cycle later, and queues it (tagged with its
// function code) in a small FIFO behind a valid/ready interface. Issue is
// credit-throttled so a pending result always has a free slot.
module alu_result_collector #(
    parameter int ALU_OUT = 32,
    parameter int DEPTH   = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               op_valid,
    input  logic [3:0]         op_fun,
    output logic               op_ready,
    input  logic [ALU_OUT-1:0] Arith_out,
    input  logic [ALU_OUT-1:0] Logic_OUT,
    input  logic [ALU_OUT-1:0] SHIFT_OUT,
    input  logic [ALU_OUT-1:0] CMP_OUT,
    input  logic               Arith_Flag,
    input  logic               Logic_Flag,
    input  logic               SHIFT_Flag,
    input  logic               CMP_Flag,
    input  logic               Carry_OUT,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [ALU_OUT-1:0] res_data,
    output logic               res_flag,
    output logic               res_carry,
    output logic [3:0]         res_fun,
    output logic               ovf_err,
    input  logic               err_clr
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [ALU_OUT-1:0] data;
        logic               flag;
        logic               carry;
        logic [3:0]         fun;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          sel;
    entry_t          head;
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [CW-1:0]   count;
    logic            pend_v;
    logic [3:0]      pend_fun;
    logic            issue;
    logic            drop;
    logic            push;
    logic            pop;

    // Credit counts the in-flight pending op as well as stored entries, so
    // the push one cycle after an issue can never find the FIFO full.
    assign op_ready  = (count + CW'(pend_v)) < CW'(DEPTH);
    assign issue     = op_valid & op_ready;
    assign drop      = op_valid & ~op_ready;
    assign push      = pend_v;
    assign res_valid = (count != '0);
    assign pop       = res_valid & res_ready;

    // Pending stage: remember which unit the ALU is producing for.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pend_v   <= 1'b0;
            pend_fun <= 4'd0;
        end else begin
            pend_v   <= issue;
            pend_fun <= op_fun;
        end
    end

    // Unit mux; only the arithmetic unit carries a meaningful carry.
    always_comb begin
        sel     = '0;
        sel.fun = pend_fun;
        unique case (pend_fun[3:2])
            2'b00: begin
                sel.data  = Arith_out;
                sel.flag  = Arith_Flag;
                sel.carry = Carry_OUT;
            end
            2'b01: begin
                sel.data = Logic_OUT;
                sel.flag = Logic_Flag;
            end
            2'b10: begin
                sel.data = CMP_OUT;
                sel.flag = CMP_Flag;
            end
            default: begin
                sel.data = SHIFT_OUT;
                sel.flag = SHIFT_Flag;
            end
        endcase
    end

    // Storage array needs no reset; validity is tracked by count.
    always_ff @(posedge CLK) begin
        if (push) mem[wptr] <= sel;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Sticky drop error; a new drop wins over a simultaneous clear.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)         ovf_err <= 1'b0;
        else if (drop)    ovf_err <= 1'b1;
        else if (err_clr) ovf_err <= 1'b0;
    end

    // Head is forced to zero when empty so outputs read as zero after reset.
    assign head      = mem[rptr];
    assign res_data  = res_valid ? head.data  : '0;
    assign res_flag  = res_valid ? head.flag  : 1'b0;
    assign res_carry = res_valid ? head.carry : 1'b0;
    assign res_fun   = res_valid ? head.fun   : 4'd0;
endmodule

// File: tb/tb_alu_result_collector.sv
// Directed bench for alu_result_collector with a small registered ALU model
// feeding the unit result buses.
module tb_alu_result_collector;
    localparam int DEPTH = 4;

    logic        CLK, RST;
    logic        op_valid, op_ready;
    logic [3:0]  op_fun;
    logic [31:0] Arith_out, Logic_OUT, SHIFT_OUT, CMP_OUT;
    logic        Arith_Flag, Logic_Flag, SHIFT_Flag, CMP_Flag, Carry_OUT;
    logic        res_valid, res_ready, res_flag, res_carry, ovf_err, err_clr;
    logic [31:0] res_data;
    logic [3:0]  res_fun;
    logic [15:0] A, B;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] d;
        logic        f;
        logic        c;
        logic [3:0]  fn;
    } exp_t;

    alu_result_collector #(.ALU_OUT(32), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .op_valid(op_valid), .op_fun(op_fun),
        .op_ready(op_ready), .Arith_out(Arith_out), .Logic_OUT(Logic_OUT),
        .SHIFT_OUT(SHIFT_OUT), .CMP_OUT(CMP_OUT), .Arith_Flag(Arith_Flag),
        .Logic_Flag(Logic_Flag), .SHIFT_Flag(SHIFT_Flag), .CMP_Flag(CMP_Flag),
        .Carry_OUT(Carry_OUT), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_flag(res_flag), .res_carry(res_carry),
        .res_fun(res_fun), .ovf_err(ovf_err), .err_clr(err_clr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ALU model: every unit registers its result from A/B each cycle.
    logic [16:0] sum_w;
    assign sum_w = {1'b0, A} + {1'b0, B};
    always @(posedge CLK) begin
        Arith_out  <= {16'h0, sum_w[15:0]};
        Carry_OUT  <= sum_w[16];
        Arith_Flag <= (sum_w[15:0] == 16'h0);
        Logic_OUT  <= {16'h0, A & B};
        Logic_Flag <= ((A & B) == 16'h0);
        CMP_OUT    <= (A == B) ? 32'd1 : (A > B) ? 32'd2 : 32'd3;
        CMP_Flag   <= (A == B);
        SHIFT_OUT  <= {16'h0, A >> 1};
        SHIFT_Flag <= A[0];
    end

    // A push into a full FIFO must never happen.
    always @(negedge CLK) begin
        if (RST) begin
            checks++;
            if (dut.pend_v && dut.count == 3'(DEPTH)) begin
                errors++;
                $display("FAIL push_when_full: count=%0d pend_v=1, required no push at count %0d", dut.count, DEPTH);
            end
        end
    end

    function automatic exp_t exp_calc(input logic [3:0] fn, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        logic [16:0] s;
        s    = {1'b0, a} + {1'b0, b};
        e.fn = fn;
        e.c  = 1'b0;
        case (fn[3:2])
            2'b00: begin e.d = {16'h0, s[15:0]}; e.f = (s[15:0] == 16'h0); e.c = s[16]; end
            2'b01: begin e.d = {16'h0, a & b}; e.f = ((a & b) == 16'h0); end
            2'b10: begin e.d = (a == b) ? 32'd1 : (a > b) ? 32'd2 : 32'd3; e.f = (a == b); end
            default: begin e.d = {16'h0, a >> 1}; e.f = a[0]; end
        endcase
        return e;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b0; op_valid = 1'b0; op_fun = 4'd0; res_ready = 1'b0;
        err_clr = 1'b0; A = 16'h0; B = 16'h0;
        #3;
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_op_ready: got %b want 1", op_ready); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
        checks++; if (res_data !== 32'h0) begin errors++; $display("FAIL reset_res_data: got %h want 0", res_data); end
        checks++; if ({res_flag, res_carry, res_fun} !== 6'h0) begin errors++; $display("FAIL reset_res_misc: got flag=%b carry=%b fun=%h want 0", res_flag, res_carry, res_fun); end
        checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL reset_ovf_err: got %b want 0", ovf_err); end
        @(posedge CLK);
        #1 RST = 1'b1;
        tick();
    endtask

    task automatic test_single_add();
        res_ready = 1'b1;
        op_valid = 1'b1; op_fun = 4'b0000; A = 16'h0005; B = 16'h0003;
        tick();
        op_valid = 1'b0;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL add_latency_n1: res_valid got %b want 0", res_valid); end
        tick();
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b want 1", res_valid); end
        checks++; if (res_data !== 32'h8 || res_carry !== 1'b0 || res_fun !== 4'h0 || res_flag !== 1'b0)
            begin errors++; $display("FAIL add_result: got data=%h c=%b f=%b fun=%h want 8/0/0/0", res_data, res_carry, res_flag, res_fun); end
        tick();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL add_popped: res_valid got %b want 0", res_valid); end
    endtask

    task automatic test_back_to_back();
        // Arith carry is 1 for these operands, so non-arith results must clear it.
        res_ready = 1'b1; A = 16'hFFFF; B = 16'h0001;
        op_valid = 1'b1; op_fun = 4'b0100;
        tick();
        op_fun = 4'b1001;
        tick();
        op_fun = 4'b1100;
        checks++; if (res_valid !== 1'b1 || res_data !== 32'h1 || res_fun !== 4'b0100 || res_carry !== 1'b0 || res_flag !== 1'b0)
            begin errors++; $display("FAIL b2b_logic: got v=%b data=%h fun=%h c=%b f=%b want 1/1/4/0/0", res_valid, res_data, res_fun, res_carry, res_flag); end
        tick();
        op_valid = 1'b0;
        checks++; if (res_valid !== 1'b1 || res_data !== 32'h2 || res_fun !== 4'b1001 || res_carry !== 1'b0 || res_flag !== 1'b0)
            begin errors++; $display("FAIL b2b_cmp: got v=%b data=%h fun=%h c=%b f=%b want 1/2/9/0/0", res_valid, res_data, res_fun, res_carry, res_flag); end
        tick();
        checks++; if (res_valid !== 1'b1 || res_data !== 32'h7FFF || res_fun !== 4'b1100 || res_carry !== 1'b0 || res_flag !== 1'b1)
            begin errors++; $display("FAIL b2b_shift: got v=%b data=%h fun=%h c=%b f=%b want 1/7fff/c/0/1", res_valid, res_data, res_fun, res_carry, res_flag); end
        tick();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: res_valid got %b want 0", res_valid); end
    endtask

    task automatic test_fill_drain();
        res_ready = 1'b0;
        // Entry i: 0x10+i + 0xFFF0 = 0x1_0000+i -> data i, carry 1, flag (i==0).
        for (int i = 0; i < 4; i++) begin
            checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d: got %b want 1", i, op_ready); end
            op_valid = 1'b1; op_fun = 4'(i); A = 16'h0010 + 16'(i); B = 16'hFFF0;
            tick();
        end
        op_valid = 1'b0;
        checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL fill_not_ready_5th: got %b want 0", op_ready); end
        tick();
        checks++; if (op_ready !== 1'b0 || ovf_err !== 1'b0) begin errors++; $display("FAIL full_state: op_ready=%b ovf_err=%b want 0/0", op_ready, ovf_err); end
        checks++; if (res_data !== 32'h0 || res_carry !== 1'b1 || res_flag !== 1'b1 || res_fun !== 4'h0)
            begin errors++; $display("FAIL full_head: got data=%h c=%b f=%b fun=%h want 0/1/1/0", res_data, res_carry, res_flag, res_fun); end
        // Dropped issue.
        op_valid = 1'b1; op_fun = 4'hF;
        tick();
        op_valid = 1'b0;
        checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL drop_sets_err: got %b want 1", ovf_err); end
        checks++; if (dut.count !== 3'd4 || op_ready !== 1'b0) begin errors++; $display("FAIL drop_count: count=%0d op_ready=%b want 4/0", dut.count, op_ready); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL err_clr: got %b want 0", ovf_err); end
        err_clr = 1'b1; op_valid = 1'b1;
        tick();
        err_clr = 1'b0; op_valid = 1'b0;
        checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL set_beats_clr: got %b want 1", ovf_err); end
        // Single pop from full: credit returns the following cycle.
        res_ready = 1'b1;
        checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL pop_same_cycle_ready: got %b want 0", op_ready); end
        tick();
        res_ready = 1'b0;
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL pop_ready_next: got %b want 1", op_ready); end
        res_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            checks++; if (res_valid !== 1'b1 || res_data !== 32'(i) || res_fun !== 4'(i) || res_carry !== 1'b1 || res_flag !== 1'b0)
                begin errors++; $display("FAIL drain_%0d: got v=%b data=%h fun=%h c=%b f=%b want 1/%0d/%0d/1/0", i, res_valid, res_data, res_fun, res_carry, res_flag, i, i); end
            tick();
        end
        res_ready = 1'b0;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: res_valid got %b want 0", res_valid); end
    endtask

    task automatic test_reset_mid();
        // ovf_err is still set from the drop test.
        res_ready = 1'b0; A = 16'h00FF; B = 16'h0F0F;
        for (int i = 0; i < 3; i++) begin
            op_valid = 1'b1; op_fun = 4'b0100 + 4'(i);
            tick();
        end
        op_valid = 1'b0;
        tick();
        checks++; if (res_valid !== 1'b1 || res_data !== 32'h0000000F || ovf_err !== 1'b1)
            begin errors++; $display("FAIL mid_pre_reset: v=%b data=%h ovf=%b want 1/f/1", res_valid, res_data, ovf_err); end
        #2 RST = 1'b0;
        #1;
        checks++; if (op_ready !== 1'b1 || res_valid !== 1'b0 || ovf_err !== 1'b0)
            begin errors++; $display("FAIL mid_reset_ctrl: op_ready=%b v=%b ovf=%b want 1/0/0", op_ready, res_valid, ovf_err); end
        checks++; if (res_data !== 32'h0 || res_flag !== 1'b0 || res_carry !== 1'b0 || res_fun !== 4'h0)
            begin errors++; $display("FAIL mid_reset_data: data=%h f=%b c=%b fun=%h want 0", res_data, res_flag, res_carry, res_fun); end
        tick();
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle_%0d: res_valid got %b want 0", i, res_valid); end
        end
    endtask

    task automatic test_wrap_around();
        exp_t q[$];
        exp_t e;
        int   issued = 0;
        int   popped = 0;
        int   cyc = 0;
        logic rr;
        logic [3:0]  fn;
        logic [15:0] a, b;
        op_valid = 1'b0; res_ready = 1'b0;
        while ((issued < 10 || popped < 10) && cyc < 300) begin
            rr = 1'($urandom_range(0, 1));
            if (res_valid && rr) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL wrap_unexpected: data=%h with empty reference", res_data);
                end else begin
                    e = q.pop_front();
                    if (res_data !== e.d || res_flag !== e.f || res_carry !== e.c || res_fun !== e.fn)
                        begin errors++; $display("FAIL wrap_item_%0d: got %h/%b/%b/%h want %h/%b/%b/%h", popped, res_data, res_flag, res_carry, res_fun, e.d, e.f, e.c, e.fn); end
                end
                popped++;
            end
            res_ready = rr;
            if (issued < 10 && op_ready) begin
                fn = 4'($urandom_range(0, 15)); a = 16'($urandom); b = 16'($urandom);
                op_valid = 1'b1; op_fun = fn; A = a; B = b;
                q.push_back(exp_calc(fn, a, b));
                issued++;
            end else begin
                op_valid = 1'b0;
            end
            checks++; if (dut.count > 3'd4) begin errors++; $display("FAIL wrap_count: got %0d want <=4", dut.count); end
            tick();
            cyc++;
        end
        op_valid = 1'b0; res_ready = 1'b0;
        checks++; if (issued != 10 || popped != 10)
            begin errors++; $display("FAIL wrap_timeout: issued=%0d popped=%0d want 10/10", issued, popped); end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_back_to_back();
        test_fill_drain();
        test_reset_mid();
        test_wrap_around();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
